// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: DIFF = A - B - BIN, LSB first, one bit per clock.
// Optional SERIAL_SUB_SAT_EN clamps diff to zero when the final borrow is set.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic            borrow;

    logic             accept;
    logic             last_bit;
    logic             d;
    logic             br_next;
    logic [WIDTH-1:0] res_final;
    logic [WIDTH-1:0] diff_final;

    assign ready    = (state == IDLE) || (state == DONE);
    assign busy     = (state == SHIFT);
    assign done     = (state == DONE);
    assign accept   = ready && start;
    assign last_bit = (cnt == CW'(WIDTH - 1));

    // Full-subtractor cell on the current LSBs and the running borrow.
    assign d         = a_sr[0] ^ b_sr[0] ^ borrow;
    assign br_next   = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow);
    assign res_final = {d, res_sr[WIDTH-1:1]};

`ifdef SERIAL_SUB_SAT_EN
    assign diff_final = br_next ? '0 : res_final;
`else
    assign diff_final = res_final;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            borrow <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            borrow <= bin;
        end else if (state == SHIFT) begin
            cnt    <= cnt + CW'(1);
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_final;
            borrow <= br_next;
            if (last_bit) begin
                diff <= diff_final;
                bout <= br_next;
            end
        end
    end

endmodule
